// File: rtl/axi_mem_arb_pkg.sv
// Shared types for the write/read controller SRAM port arbiter.
// Holds the owner encoding, the default-width request record and the byte-enable width helper.
package axi_mem_arb_pkg;

  typedef enum logic {OWNER_W = 1'b0, OWNER_R = 1'b1} owner_t;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 64;

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

  localparam int BE_W_DEF = be_width(DATA_W_DEF);

  typedef struct packed {
    logic                  cen;
    logic                  wen;
    logic [ADDR_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] d;
    logic [BE_W_DEF-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_sticky_rr.sv
// Sticky round-robin grant decision between the write and read controllers.
// The current owner keeps the port for up to MAX_BURST grants while the other side waits.
module mem_arb_sticky_rr
  import axi_mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic w_req,
  input  logic r_req,
  output logic w_gnt,
  output logic r_gnt
);

  localparam int             CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_BURST);

  owner_t          last_q, last_d, winner;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            any_req;

  always_comb begin
    any_req = w_req | r_req;
    winner  = OWNER_W;
    if (w_req && r_req)
      winner = (cnt_q < CNT_MAX) ? last_q : owner_t'(~last_q);
    else if (r_req)
      winner = OWNER_R;

    last_d = last_q;
    cnt_d  = cnt_q;
    // Idle cycles leave the history untouched.
    if (any_req) begin
      if (winner == last_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end else begin
        last_d = winner;
        cnt_d  = CW'(1);
      end
    end

    w_gnt = rst_n && any_req && (winner == OWNER_W);
    r_gnt = rst_n && any_req && (winner == OWNER_R);
  end

  // Reset to a saturated read owner so the first conflict goes to the write side.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWNER_R;
      cnt_q  <= CNT_MAX;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_mem_port_arbiter.sv
// Merges the write and read controllers onto one single-port SRAM and routes read data back.
// Optional performance counters are compiled in with `define MEM_ARB_PERF_CNT_EN.
module axi_mem_port_arbiter
  import axi_mem_arb_pkg::*;
#(
  parameter  int MEM_ADDR_WIDTH = 16,
  parameter  int DATA_WIDTH     = 64,
  parameter  int MAX_BURST      = 4,
  localparam int BE_WIDTH       = be_width(DATA_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      W_VALID_i,
  input  logic                      W_CEN_i,
  input  logic                      W_WEN_i,
  input  logic [MEM_ADDR_WIDTH-1:0] W_A_i,
  input  logic [DATA_WIDTH-1:0]     W_D_i,
  input  logic [BE_WIDTH-1:0]       W_BE_i,
  output logic                      W_GRANT_o,
  output logic                      W_RVALID_o,
  input  logic                      R_VALID_i,
  input  logic                      R_CEN_i,
  input  logic                      R_WEN_i,
  input  logic [MEM_ADDR_WIDTH-1:0] R_A_i,
  input  logic [DATA_WIDTH-1:0]     R_D_i,
  input  logic [BE_WIDTH-1:0]       R_BE_i,
  output logic                      R_GRANT_o,
  output logic                      R_RVALID_o,
  output logic [DATA_WIDTH-1:0]     Q_o,
  output logic                      MEM_CEN_o,
  output logic                      MEM_WEN_o,
  output logic [MEM_ADDR_WIDTH-1:0] MEM_A_o,
  output logic [DATA_WIDTH-1:0]     MEM_D_o,
  output logic [BE_WIDTH-1:0]       MEM_BE_o,
  input  logic [DATA_WIDTH-1:0]     MEM_Q_i
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]               conflict_cnt_o,
  output logic [31:0]               w_stall_cnt_o,
  output logic [31:0]               r_stall_cnt_o
`endif
);

  typedef struct packed {
    logic                      cen;
    logic                      wen;
    logic [MEM_ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0]     d;
    logic [BE_WIDTH-1:0]       be;
  } req_t;

  req_t w_req, r_req, mem_req;
  logic w_rvalid_q, r_rvalid_q;

  mem_arb_sticky_rr #(.MAX_BURST(MAX_BURST)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .w_req (W_VALID_i),
    .r_req (R_VALID_i),
    .w_gnt (W_GRANT_o),
    .r_gnt (R_GRANT_o)
  );

  always_comb begin
    w_req = '{cen: W_CEN_i, wen: W_WEN_i, a: W_A_i, d: W_D_i, be: W_BE_i};
    r_req = '{cen: R_CEN_i, wen: R_WEN_i, a: R_A_i, d: R_D_i, be: R_BE_i};
    mem_req = '{cen: 1'b1, wen: 1'b1, default: '0};
    if (W_GRANT_o)      mem_req = w_req;
    else if (R_GRANT_o) mem_req = r_req;
  end

  assign MEM_CEN_o = mem_req.cen;
  assign MEM_WEN_o = mem_req.wen;
  assign MEM_A_o   = mem_req.a;
  assign MEM_D_o   = mem_req.d;
  assign MEM_BE_o  = mem_req.be;
  assign Q_o       = MEM_Q_i;

  // SRAM read latency is one cycle: tag the returning data with the granted reader.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_rvalid_q <= 1'b0;
      r_rvalid_q <= 1'b0;
    end else begin
      w_rvalid_q <= W_GRANT_o && !W_CEN_i && W_WEN_i;
      r_rvalid_q <= R_GRANT_o && !R_CEN_i && R_WEN_i;
    end
  end

  assign W_RVALID_o = w_rvalid_q;
  assign R_RVALID_o = r_rvalid_q;

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_o <= '0;
      w_stall_cnt_o  <= '0;
      r_stall_cnt_o  <= '0;
    end else begin
      if (W_VALID_i && R_VALID_i) conflict_cnt_o <= conflict_cnt_o + 32'd1;
      if (W_VALID_i && !W_GRANT_o) w_stall_cnt_o <= w_stall_cnt_o + 32'd1;
      if (R_VALID_i && !R_GRANT_o) r_stall_cnt_o <= r_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
